uart_rx_framed: RTL and testbench



---
 rtl/uart_rx_framed.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framed.sv
// Framed UART receiver with majority-voted sampling, optional parity, 1/2 stop bits,
// break detection and a one-entry valid/ready output buffer with sticky overrun.
`timescale 1ns/1ps
module uart_rx_framed #(
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned BIT_RATE     = 9600,
   parameter int unsigned PAYLOAD_BITS = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   output logic [PAYLOAD_BITS-1:0] m_data,
   output logic                    m_parity_err,
   output logic                    m_frame_err,
   output logic                    m_break,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    overrun,
   input  logic                    overrun_clr
);
   localparam int unsigned CPB = CLK_HZ / BIT_RATE;
   localparam int unsigned H   = CPB / 2;
   localparam int unsigned CW  = $clog2(CPB);
   localparam int unsigned BW  = $clog2(PAYLOAD_BITS);

   localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(H);
   localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
   localparam logic [CW-1:0] CNT_END  = CW'(CPB - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic [1:0]              sync_q;
   logic                    rxd_s;
   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW-1:0]           bit_idx_q, bit_idx_d;
   logic                    stop_idx_q, stop_idx_d;
   logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
   logic                    par_q, par_d;
   logic                    fe_q, fe_d;
   logic                    s0_q, s1_q;
   logic                    vote;
   logic                    last_stop;
   logic                    par_odd;

   logic                    done;
   logic                    done_fe;
   logic                    done_pe;
   logic                    done_brk;

   logic [PAYLOAD_BITS-1:0] data_q;
   logic                    pe_q, fef_q, brk_q, valid_q, ovr_q;
   logic                    accept;

   // Disabling the receiver parks the synchroniser at idle so re-enable cannot see a stale low.
   always_ff @(posedge clk) begin
      if (!resetn || !uart_rx_en) sync_q <= '1;
      else                        sync_q <= {sync_q[0], uart_rxd};
   end
   assign rxd_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         s0_q <= 1'b1;
         s1_q <= 1'b1;
      end else begin
         if (cnt_q == CNT_S0) s0_q <= rxd_s;
         if (cnt_q == CNT_S1) s1_q <= rxd_s;
      end
   end

   assign vote      = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);
   assign last_stop = (STOP_BITS == 1) || stop_idx_q;
   assign par_odd   = ^{shift_q, par_q};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         fe_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         fe_q       <= fe_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q == CNT_END) ? '0 : cnt_q + 1'b1;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      fe_d       = fe_q;
      done       = 1'b0;
      done_fe    = fe_q | ~vote;
      done_pe    = (PARITY == 1) ? par_odd : ((PARITY == 2) ? ~par_odd : 1'b0);
      done_brk   = (shift_q == '0) && ((PARITY == 0) || !par_q) && !vote;

      case (state_q)
         S_IDLE: begin
            // The detecting cycle is count 0, so the next cycle starts at 1.
            cnt_d      = CW'(1);
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            fe_d       = 1'b0;
            if (!rxd_s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_DEC && vote) state_d = S_IDLE;
            else if (cnt_q == CNT_END)    state_d = S_DATA;
         end
         S_DATA: begin
            if (cnt_q == CNT_DEC) shift_d = {vote, shift_q[PAYLOAD_BITS-1:1]};
            if (cnt_q == CNT_END) begin
               if (bit_idx_q == LAST_BIT) begin
                  bit_idx_d = '0;
                  state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (cnt_q == CNT_DEC) par_d = vote;
            if (cnt_q == CNT_END) state_d = S_STOP;
         end
         S_STOP: begin
            if (cnt_q == CNT_DEC) begin
               fe_d = done_fe;
               if (last_stop) begin
                  done    = uart_rx_en;
                  state_d = done_fe ? S_WAIT_HIGH : S_IDLE;
               end
            end else if (cnt_q == CNT_END) begin
               stop_idx_d = 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (rxd_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (!uart_rx_en) state_d = S_IDLE;
   end

   assign accept = !valid_q || m_ready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         data_q  <= '0;
         pe_q    <= 1'b0;
         fef_q   <= 1'b0;
         brk_q   <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         if (done && accept) begin
            data_q  <= shift_q;
            pe_q    <= done_pe;
            fef_q   <= done_fe;
            brk_q   <= done_brk;
            valid_q <= 1'b1;
         end else if (valid_q && m_ready) begin
            valid_q <= 1'b0;
         end
         if (done && !accept) ovr_q <= 1'b1;
         else if (overrun_clr) ovr_q <= 1'b0;
      end
   end

   assign m_data       = data_q;
   assign m_parity_err = pe_q;
   assign m_frame_err  = fef_q;
   assign m_break      = brk_q;
   assign m_valid      = valid_q;
   assign overrun      = ovr_q;
endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: an 8N1 instance and an even-parity two-stop-bit instance
// driven with directed and random frames, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_framed;
   localparam int CPB = 10;
   localparam int H   = 5;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       brk;
   } rec_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic       a_rxd = 1'b1, a_en = 1'b1, a_ready = 1'b1, a_oclr = 1'b0;
   logic [7:0] a_data;
   logic       a_pe, a_fe, a_brk, a_valid, a_ovr;
   logic       b_rxd = 1'b1, b_en = 1'b1, b_ready = 1'b1, b_oclr = 1'b0;
   logic [7:0] b_data;
   logic       b_pe, b_fe, b_brk, b_valid, b_ovr;

   uart_rx_framed #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8),
                    .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .resetn(resetn), .uart_rxd(a_rxd), .uart_rx_en(a_en),
      .m_data(a_data), .m_parity_err(a_pe), .m_frame_err(a_fe), .m_break(a_brk),
      .m_valid(a_valid), .m_ready(a_ready), .overrun(a_ovr), .overrun_clr(a_oclr));

   uart_rx_framed #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8),
                    .PARITY(1), .STOP_BITS(2)) u_b (
      .clk(clk), .resetn(resetn), .uart_rxd(b_rxd), .uart_rx_en(b_en),
      .m_data(b_data), .m_parity_err(b_pe), .m_frame_err(b_fe), .m_break(b_brk),
      .m_valid(b_valid), .m_ready(b_ready), .overrun(b_ovr), .overrun_clr(b_oclr));

   int   total = 0;
   int   bad = 0;
   int   vcyc_a = 0;
   rec_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];

   always @(negedge clk) begin
      if (resetn) begin
         if (a_valid) vcyc_a++;
         if (a_valid && a_ready) obs_a.push_back(rec_t'{d: a_data, pe: a_pe, fe: a_fe, brk: a_brk});
         if (b_valid && b_ready) obs_b.push_back(rec_t'{d: b_data, pe: b_pe, fe: b_fe, brk: b_brk});
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Frame-level model: line 0 is 8N1, line 1 is 8 data + even parity + 2 stop bits.
   function automatic rec_t model(input int line, input logic [7:0] d, input logic p,
                                  input logic s1, input logic s2);
      rec_t r;
      logic last;
      r.d   = d;
      last  = (line == 0) ? s1 : s2;
      r.pe  = (line == 1) && ((($countones(d) + int'(p)) % 2) == 1);
      r.fe  = !last || (line == 1 && !s1);
      r.brk = (d == 8'h00) && (line == 0 || !p) && !last;
      return r;
   endfunction

   task automatic drive(input int line, input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         if (line == 0) a_rxd = lvl;
         else           b_rxd = lvl;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int line, input logic [7:0] d, input logic p,
                             input logic s1, input logic s2, input int gb, input int gc);
      logic lv[$];
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(d[i]);
      if (line == 1) begin
         lv.push_back(p);
         lv.push_back(s1);
         lv.push_back(s2);
      end else begin
         lv.push_back(s1);
      end
      for (int b = 0; b < lv.size(); b++)
         for (int c = 0; c < CPB; c++)
            drive(line, lv[b] ^ ((b == gb && c == gc) ? 1'b1 : 1'b0), 1);
   endtask

   task automatic tx(input int line, input logic [7:0] d, input logic p,
                     input logic s1, input logic s2);
      send_frame(line, d, p, s1, s2, -1, 0);
      if (line == 0) exp_a.push_back(model(0, d, p, s1, s2));
      else           exp_b.push_back(model(1, d, p, s1, s2));
      drive(line, 1'b1, CPB * int'($urandom_range(1, 2)) + int'($urandom_range(0, 3)));
   endtask

   task automatic check_q(input int line, input string tag);
      rec_t o, e;
      if (line == 0) begin
         check({tag, "_cnt"}, obs_a.size(), exp_a.size());
         while (obs_a.size() > 0 && exp_a.size() > 0) begin
            o = obs_a.pop_front();
            e = exp_a.pop_front();
            check(tag, o, e);
         end
         obs_a.delete();
         exp_a.delete();
      end else begin
         check({tag, "_cnt"}, obs_b.size(), exp_b.size());
         while (obs_b.size() > 0 && exp_b.size() > 0) begin
            o = obs_b.pop_front();
            e = exp_b.pop_front();
            check(tag, o, e);
         end
         obs_b.delete();
         exp_b.delete();
      end
   endtask

   initial begin
      logic [7:0] d;
      logic       p, s1, s2;

      repeat (3) @(posedge clk);
      #1;
      check("rst_a", {a_valid, a_data, a_pe, a_fe, a_brk, a_ovr}, 32'h0);
      check("rst_b", {b_valid, b_data, b_pe, b_fe, b_brk, b_ovr}, 32'h0);
      resetn = 1'b1;
      drive(0, 1'b1, 20);

      // 8N1 0xA5: one-cycle valid pulse with ready held high
      vcyc_a = 0;
      tx(0, 8'hA5, 1'b0, 1'b1, 1'b1);
      check("t1_vcyc", vcyc_a, 1);
      check("t1_ovr", a_ovr, 1'b0);
      check_q(0, "t1");

      // short low pulse on idle line is a false start
      drive(0, 1'b0, 3);
      drive(0, 1'b1, 3 * CPB);
      check_q(0, "t3_false_start");

      // single-cycle glitch at the centre sample of a data bit is outvoted
      send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, 3, H);
      exp_a.push_back(model(0, 8'h5A, 1'b0, 1'b1, 1'b1));
      drive(0, 1'b1, 2 * CPB);
      check_q(0, "t3_glitch");

      // held-low break yields exactly one frame, then a clean frame follows
      drive(0, 1'b0, 30 * CPB);
      check("t4_one_frame", obs_a.size(), 1);
      exp_a.push_back(model(0, 8'h00, 1'b0, 1'b0, 1'b0));
      drive(0, 1'b1, 2 * CPB);
      tx(0, 8'h41, 1'b0, 1'b1, 1'b1);
      check_q(0, "t4");

      // disabling mid-frame discards the partial frame
      drive(0, 1'b0, CPB + H);
      a_en = 1'b0;
      drive(0, 1'b1, 3);
      a_en = 1'b1;
      drive(0, 1'b1, 12 * CPB);
      check_q(0, "en_abort");

      for (int n = 0; n < 16; n++) begin
         d  = 8'($urandom);
         s1 = ($urandom_range(0, 3) != 0);
         tx(0, d, 1'b0, s1, 1'b1);
      end
      check_q(0, "rand_a");

      // overrun: second frame dropped while the buffer is held
      a_ready = 1'b0;
      tx(0, 8'h11, 1'b0, 1'b1, 1'b1);
      send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, -1, 0);
      drive(0, 1'b1, 2 * CPB);
      check("t5_valid", a_valid, 1'b1);
      check("t5_data", a_data, 8'h11);
      check("t5_ovr", a_ovr, 1'b1);
      a_ready = 1'b1;
      @(posedge clk);
      #1;
      a_ready = 1'b0;
      check("t5_valid_fall", a_valid, 1'b0);
      check("t5_ovr_sticky", a_ovr, 1'b1);
      a_oclr = 1'b1;
      @(posedge clk);
      #1;
      a_oclr = 1'b0;
      check("t5_ovr_clr", a_ovr, 1'b0);
      a_ready = 1'b1;
      check_q(0, "t5");

      // even parity, two stop bits
      drive(1, 1'b1, 2 * CPB);
      tx(1, 8'h03, 1'b0, 1'b1, 1'b1);
      tx(1, 8'h03, 1'b1, 1'b1, 1'b1);
      check_q(1, "t2");

      for (int n = 0; n < 12; n++) begin
         d  = 8'($urandom);
         p  = 1'($urandom);
         s1 = ($urandom_range(0, 4) != 0);
         s2 = ($urandom_range(0, 4) != 0);
         tx(1, d, p, s1, s2);
      end
      check_q(1, "rand_b");

      tx(1, 8'h5C, 1'b0, 1'b1, 1'b0);
      check_q(1, "t6_stop2");

      // reset in the middle of a frame, then a clean frame
      drive(1, 1'b0, CPB);
      send_frame(1, 8'h00, 1'b0, 1'b0, 1'b0, -1, 0);
      exp_b.push_back(model(1, 8'h00, 1'b0, 1'b0, 1'b0));
      check_q(1, "brk_b");
      drive(1, 1'b1, 2 * CPB);
      drive(1, 1'b0, 4 * CPB + 3);
      b_rxd  = 1'b1;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("t6_rst_b", {b_valid, b_data, b_pe, b_fe, b_brk, b_ovr}, 32'h0);
      resetn = 1'b1;
      drive(1, 1'b1, 3 * CPB);
      check_q(1, "t6_after_rst_idle");
      tx(1, 8'h3C, 1'b0, 1'b1, 1'b1);
      check_q(1, "t6_clean");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
